// File: rtl/core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | core_pkg : shared RV32I core types and constants for the ID/EX stage       |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
package core_pkg;

  localparam int XLEN = 32;

  // Result mux select encodings
  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

  typedef struct packed {
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic       MemWrite;
    logic       Jump;
    logic       Branch;
    logic [2:0] ALUControl;
    logic       ALUSrc;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage
`default_nettype wire

// File: rtl/id_ex_pipe_reg_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | id_ex_pipe_reg_if : decode-side bundle in, execute-side bundle out         |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
interface id_ex_pipe_reg_if import core_pkg::*; #(
  parameter int CNT_W = 16
);
  logic            StallE, FlushE;
  logic            ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]      ResultSrcD;
  logic [2:0]      ALUControlD;
  logic [XLEN-1:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [4:0]      Rs1D, Rs2D, RdD;

  logic            ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]      ResultSrcE;
  logic [2:0]      ALUControlE;
  logic [XLEN-1:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [4:0]      Rs1E, Rs2E, RdE;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output StallE, FlushE, ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
           ResultSrcD, ALUControlD, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
    input  ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
           ResultSrcE, ALUControlE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE,
           bubble_cnt
  );

  modport slave (
    input  StallE, FlushE, ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
           ResultSrcD, ALUControlD, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
    output ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
           ResultSrcE, ALUControlE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE,
           bubble_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_field_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_field_reg : W-bit pipeline field, async clear, sync clr over enable   |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
module pipe_field_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end
endmodule
`default_nettype wire

// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | id_ex_pipe_reg : ID->EX pipeline register with stall/flush and bubble count|
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
module id_ex_pipe_reg import core_pkg::*; #(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  id_ex_pipe_reg_if.slave      bus
);
  localparam int CTRL_W = $bits(ctrl_t);
  localparam int IDX_W  = 16;
  localparam int DATA_W = 5 * XLEN;

  logic              load_en;
  logic              bubble;
  ctrl_t             ctrl_d, ctrl_q;
  logic [IDX_W-1:0]  idx_d, idx_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic [CNT_W-1:0]  cnt_q;

  assign load_en = ~bus.StallE;

  // Non-valid slots carry no side effects: control is zeroed before capture
  always_comb begin
    ctrl_d = CTRL_NOP;
    if (bus.ValidD) begin
      ctrl_d.RegWrite   = bus.RegWriteD;
      ctrl_d.ResultSrc  = bus.ResultSrcD;
      ctrl_d.MemWrite   = bus.MemWriteD;
      ctrl_d.Jump       = bus.JumpD;
      ctrl_d.Branch     = bus.BranchD;
      ctrl_d.ALUControl = bus.ALUControlD;
      ctrl_d.ALUSrc     = bus.ALUSrcD;
    end
  end

  assign idx_d  = {bus.ValidD, bus.Rs1D, bus.Rs2D, bus.RdD};
  assign data_d = {bus.RD1D, bus.RD2D, bus.PCD, bus.PCPlus4D, bus.ImmExtD};

  pipe_field_reg #(.W(CTRL_W)) u_ctrl (
    .clk(clk), .rst_n(rst_n), .en(load_en), .clr(bus.FlushE), .d(ctrl_d), .q(ctrl_q)
  );

  pipe_field_reg #(.W(IDX_W)) u_idx (
    .clk(clk), .rst_n(rst_n), .en(load_en), .clr(bus.FlushE), .d(idx_d), .q(idx_q)
  );

  pipe_field_reg #(.W(DATA_W)) u_data (
    .clk(clk), .rst_n(rst_n), .en(load_en), .clr(bus.FlushE), .d(data_d), .q(data_q)
  );

  assign bus.RegWriteE   = ctrl_q.RegWrite;
  assign bus.ResultSrcE  = ctrl_q.ResultSrc;
  assign bus.MemWriteE   = ctrl_q.MemWrite;
  assign bus.JumpE       = ctrl_q.Jump;
  assign bus.BranchE     = ctrl_q.Branch;
  assign bus.ALUControlE = ctrl_q.ALUControl;
  assign bus.ALUSrcE     = ctrl_q.ALUSrc;
  assign {bus.ValidE, bus.Rs1E, bus.Rs2E, bus.RdE} = idx_q;
  assign {bus.RD1E, bus.RD2E, bus.PCE, bus.PCPlus4E, bus.ImmExtE} = data_q;

  // A flush always counts, even when stall is also high
  assign bubble = bus.FlushE | (load_en & ~bus.ValidD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt_q <= '0;
    else if (bubble && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end

  assign bus.bubble_cnt = cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_id_ex_pipe_reg : directed vectors for id_ex_pipe_reg (16b and 4b count) |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
module tb_id_ex_pipe_reg;
  import core_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  id_ex_pipe_reg_if #(.CNT_W(16)) bb ();
  id_ex_pipe_reg_if #(.CNT_W(4))  sb ();

  id_ex_pipe_reg #(.CNT_W(16)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bb));
  id_ex_pipe_reg #(.CNT_W(4))  u_sat (.clk(clk), .rst_n(rst_n), .bus(sb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    {bb.StallE, bb.FlushE, bb.ValidD, bb.RegWriteD, bb.MemWriteD, bb.JumpD, bb.BranchD, bb.ALUSrcD} = '0;
    bb.ResultSrcD = '0; bb.ALUControlD = '0;
    {bb.RD1D, bb.RD2D, bb.PCD, bb.PCPlus4D, bb.ImmExtD} = '0;
    {bb.Rs1D, bb.Rs2D, bb.RdD} = '0;
    // Small instance sits stalled (holds zero) until the saturation run
    {sb.StallE, sb.FlushE} = 2'b10;
    {sb.ValidD, sb.RegWriteD, sb.MemWriteD, sb.JumpD, sb.BranchD, sb.ALUSrcD} = '0;
    sb.ResultSrcD = '0; sb.ALUControlD = '0;
    {sb.RD1D, sb.RD2D, sb.PCD, sb.PCPlus4D, sb.ImmExtD} = '0;
    {sb.Rs1D, sb.Rs2D, sb.RdD} = '0;
    repeat (2) tick();
    rst_n = 1'b1;

    // Nonzero load so the reset check has something to clear
    bb.ValidD = 1; bb.RegWriteD = 1; bb.ResultSrcD = RES_PC4; bb.MemWriteD = 1;
    bb.JumpD = 1; bb.BranchD = 1; bb.ALUControlD = 3'd5; bb.ALUSrcD = 1;
    bb.RD1D = 32'hDEADBEEF; bb.RD2D = 32'h12345678; bb.PCD = 32'h100; bb.PCPlus4D = 32'h104;
    bb.ImmExtD = 32'h7FF; bb.Rs1D = 5'd3; bb.Rs2D = 5'd4; bb.RdD = 5'd9;
    tick();
    chk("pre_rd", bb.RdE, 9);
    chk("pre_pc4", bb.PCPlus4E, 32'h104);
    chk("pre_memwr", bb.MemWriteE, 1);

    // 1: async reset mid-cycle, no clock edge in between
    #3 rst_n = 1'b0;
    #1;
    chk("rst_rd", bb.RdE, 0);
    chk("rst_regwr", bb.RegWriteE, 0);
    chk("rst_memwr", bb.MemWriteE, 0);
    chk("rst_valid", bb.ValidE, 0);
    chk("rst_imm", bb.ImmExtE, 0);
    chk("rst_rd1", bb.RD1E, 0);
    chk("rst_pc", bb.PCE, 0);
    chk("rst_ctl", {bb.JumpE, bb.BranchE, bb.ALUSrcE, bb.ResultSrcE, bb.ALUControlE}, 0);
    chk("rst_cnt", bb.bubble_cnt, 0);
    chk("rst_sat_cnt", sb.bubble_cnt, 0);
    #2 rst_n = 1'b1;

    // 2: plain load
    bb.ImmExtD = 32'hFFFFF800; bb.RD1D = 32'h10; bb.RdD = 5'd5; bb.RegWriteD = 1; bb.ValidD = 1;
    tick();
    chk("ld_imm", bb.ImmExtE, 32'hFFFFF800);
    chk("ld_rd", bb.RdE, 5);
    chk("ld_regwr", bb.RegWriteE, 1);
    chk("ld_valid", bb.ValidE, 1);
    chk("ld_rd1", bb.RD1E, 32'h10);
    chk("ld_cnt", bb.bubble_cnt, 0);

    // 3: stall holds everything for 3 edges
    bb.StallE = 1; bb.ImmExtD = 32'h4; bb.RdD = 5'd7; bb.ValidD = 0;
    repeat (3) tick();
    chk("stl_imm", bb.ImmExtE, 32'hFFFFF800);
    chk("stl_rd", bb.RdE, 5);
    chk("stl_valid", bb.ValidE, 1);
    chk("stl_cnt", bb.bubble_cnt, 0);

    // 4: flush beats stall
    bb.FlushE = 1; bb.MemWriteD = 1; bb.ValidD = 1;
    tick();
    chk("fl_memwr", bb.MemWriteE, 0);
    chk("fl_valid", bb.ValidE, 0);
    chk("fl_rd", bb.RdE, 0);
    chk("fl_regwr", bb.RegWriteE, 0);
    chk("fl_imm", bb.ImmExtE, 0);
    chk("fl_pc", bb.PCE, 0);
    chk("fl_cnt", bb.bubble_cnt, 1);

    // 5: invalid slot loads data but gated control
    bb.FlushE = 0; bb.StallE = 0; bb.ValidD = 0; bb.RegWriteD = 1; bb.MemWriteD = 1; bb.JumpD = 1;
    tick();
    chk("inv_regwr", bb.RegWriteE, 0);
    chk("inv_memwr", bb.MemWriteE, 0);
    chk("inv_jump", bb.JumpE, 0);
    chk("inv_valid", bb.ValidE, 0);
    chk("inv_rsrc", bb.ResultSrcE, 0);
    chk("inv_rd", bb.RdE, 7);
    chk("inv_imm", bb.ImmExtE, 32'h4);
    chk("inv_cnt", bb.bubble_cnt, 2);

    // Valid load after the bubble: full control passes through
    bb.ValidD = 1;
    tick();
    chk("vld_rsrc", bb.ResultSrcE, RES_PC4);
    chk("vld_alu", bb.ALUControlE, 5);
    chk("vld_ctl", {bb.RegWriteE, bb.MemWriteE, bb.JumpE, bb.BranchE, bb.ALUSrcE, bb.ValidE}, 6'b111111);
    chk("vld_rs", {bb.Rs1E, bb.Rs2E}, {5'd3, 5'd4});
    chk("vld_cnt", bb.bubble_cnt, 2);

    // Reset during a stall clears state immediately
    bb.StallE = 1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rstst_valid", bb.ValidE, 0);
    chk("rstst_cnt", bb.bubble_cnt, 0);
    #2 rst_n = 1'b1;
    bb.StallE = 0;

    // 6: 4-bit counter saturates at 15
    sb.StallE = 0; sb.FlushE = 1;
    repeat (14) tick();
    chk("sat_14", sb.bubble_cnt, 14);
    tick();
    chk("sat_15", sb.bubble_cnt, 15);
    repeat (5) tick();
    chk("sat_hold", sb.bubble_cnt, 15);
    chk("sat_valid", sb.ValidE, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
